// File: rtl/button_conditioner.sv
// Two-channel pushbutton conditioner: synchronise, debounce, one-cycle press strobes, mode flip-flop.
// Define TRIGGER_AUTO_REPEAT_EN to add hold-to-repeat strobes on the trigger channel.

// Purpose: trigger/toggle button front end feeding the counter's trigger and toggle inputs.
// Latency: press strobe DEBOUNCE_CYCLES+2 cycles after the first edge that samples the raw level high.
// Backpressure: none; strobes are fire-and-forget single-cycle pulses.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic clock,
  input  logic reset,
  input  logic trigger_raw,
  input  logic toggle_raw,
  output logic trigger_pulse,
  output logic toggle_pulse,
  output logic trigger_held,
  output logic mode
);

  localparam int MAX_DR = (REPEAT_DELAY > DEBOUNCE_CYCLES) ? REPEAT_DELAY : DEBOUNCE_CYCLES;
  localparam int MAXP   = (REPEAT_PERIOD > MAX_DR) ? REPEAT_PERIOD : MAX_DR;
  localparam int CW     = $clog2(MAXP + 1);
  localparam int TRIG   = 0;
  localparam int TOG    = 1;

  localparam logic [CW-1:0] DC   = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CMAX = {CW{1'b1}};

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_t;

  logic [1:0]    sync_1;
  logic [1:0]    sync_2;
  state_t        state     [2];
  state_t        state_nxt [2];
  logic [CW-1:0] cnt       [2];
  logic [CW-1:0] cnt_nxt   [2];
  logic [CW-1:0] cnt_inc   [2];
  logic [1:0]    enter_held;
  logic [1:0]    press_q;

  // Raw buttons are asynchronous: nothing looks at them before the second flop.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_1 <= 2'b00;
      sync_2 <= 2'b00;
    end else begin
      sync_1 <= {toggle_raw, trigger_raw};
      sync_2 <= sync_1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int c = 0; c < 2; c++) begin
        state[c] <= IDLE;
        cnt[c]   <= '0;
      end
      press_q <= 2'b00;
    end else begin
      for (int c = 0; c < 2; c++) begin
        state[c] <= state_nxt[c];
        cnt[c]   <= cnt_nxt[c];
      end
      press_q <= enter_held;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    enter_held = 2'b00;
    for (int c = 0; c < 2; c++) begin
      // Saturating increment keeps a stuck level from ever wrapping the count.
      cnt_inc[c] = (cnt[c] == CMAX) ? cnt[c] : cnt[c] + CW'(1);
      case (state[c])
        IDLE: begin
          if (sync_2[c]) begin
            state_nxt[c] = PRESS_WAIT;
            cnt_nxt[c]   = '0;
          end
        end
        PRESS_WAIT: begin
          if (!sync_2[c]) begin
            state_nxt[c] = IDLE;
            cnt_nxt[c]   = '0;
          end else begin
            cnt_nxt[c] = cnt_inc[c];
            if (cnt_inc[c] >= DC) begin
              state_nxt[c]  = HELD;
              enter_held[c] = 1'b1;
            end
          end
        end
        HELD: begin
          if (!sync_2[c]) begin
            state_nxt[c] = RELEASE_WAIT;
            cnt_nxt[c]   = '0;
          end
        end
        RELEASE_WAIT: begin
          if (sync_2[c]) begin
            state_nxt[c] = HELD;
            cnt_nxt[c]   = '0;
          end else begin
            cnt_nxt[c] = cnt_inc[c];
            if (cnt_inc[c] >= DC) begin
              state_nxt[c] = IDLE;
            end
          end
        end
        default: begin
          state_nxt[c] = IDLE;
          cnt_nxt[c]   = '0;
        end
      endcase
    end
  end

  assign trigger_held = (state[TRIG] == HELD) || (state[TRIG] == RELEASE_WAIT);
  assign toggle_pulse = press_q[TOG];

`ifdef TRIGGER_AUTO_REPEAT_EN
  localparam logic [CW-1:0] RD = CW'(REPEAT_DELAY);
  localparam logic [CW-1:0] RP = CW'(REPEAT_PERIOD);

  logic [CW-1:0] rep_cnt;
  logic [CW-1:0] rep_inc;
  logic [CW-1:0] rep_target;
  logic          rep_armed;
  logic          rep_pulse;
  logic          trig_stay;

  // First strobe after REPEAT_DELAY held cycles, then every REPEAT_PERIOD.
  assign rep_inc    = (rep_cnt == CMAX) ? rep_cnt : rep_cnt + CW'(1);
  assign rep_target = rep_armed ? RP : RD;
  assign trig_stay  = (state[TRIG] == HELD) && sync_2[TRIG];

  // Release bounce pauses the count; only a full release back to idle clears it.
  always_ff @(posedge clock) begin
    if (reset || !trigger_held) begin
      rep_cnt   <= '0;
      rep_armed <= 1'b0;
      rep_pulse <= 1'b0;
    end else if (trig_stay) begin
      if (rep_inc == rep_target) begin
        rep_cnt   <= '0;
        rep_armed <= 1'b1;
        rep_pulse <= 1'b1;
      end else begin
        rep_cnt   <= rep_inc;
        rep_pulse <= 1'b0;
      end
    end else begin
      rep_pulse <= 1'b0;
    end
  end

  assign trigger_pulse = press_q[TRIG] | rep_pulse;
`else
  assign trigger_pulse = press_q[TRIG];
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      mode <= 1'b0;
    end else if (toggle_pulse) begin
      mode <= ~mode;
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Randomised bench: a run-length debounce model predicts every output cycle; a monitor checks the DUT.
// Honours TRIGGER_AUTO_REPEAT_EN the same way the design does.
module tb_button_conditioner;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic trigger_raw = 1'b0;
  logic toggle_raw = 1'b0;
  logic trigger_pulse, toggle_pulse, trigger_held, mode;

  button_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .trigger_raw  (trigger_raw),
    .toggle_raw   (toggle_raw),
    .trigger_pulse(trigger_pulse),
    .toggle_pulse (toggle_pulse),
    .trigger_held (trigger_held),
    .mode         (mode)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic tp;
    logic gp;
    logic th;
    logic md;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // Reference model: the accepted level of a button flips after DB+1 consecutive
  // synchronised samples that disagree with it; raw input reaches the debouncer two edges late.
  bit t_d1, t_d2, g_d1, g_d2;
  bit t_lvl, g_lvl;
  int t_run, g_run, t_hold, g_hold;
  bit m_mode, m_gp_prev;

  task automatic chan_step(input bit s, inout bit lvl, inout int run, inout int hold,
                           input bit rep_en, output bit p);
    p = 1'b0;
    if (s != lvl) begin
      run++;
      if (run == DB + 1) begin
        lvl  = s;
        run  = 0;
        hold = 0;
        p    = s;
      end
    end else begin
      if (rep_en && lvl && run == 0) begin
        hold++;
`ifdef TRIGGER_AUTO_REPEAT_EN
        if (hold == RD || (hold > RD && (hold - RD) % RP == 0)) p = 1'b1;
`endif
      end
      run = 0;
    end
  endtask

  task automatic model_edge(input bit rst, input bit tr, input bit gr, output exp_t e);
    bit ts, gs, tp, gp;
    if (rst) begin
      t_d1 = 0; t_d2 = 0; g_d1 = 0; g_d2 = 0;
      t_lvl = 0; g_lvl = 0; t_run = 0; g_run = 0; t_hold = 0; g_hold = 0;
      m_mode = 0; m_gp_prev = 0;
      e = '0;
    end else begin
      ts = t_d2; t_d2 = t_d1; t_d1 = tr;
      gs = g_d2; g_d2 = g_d1; g_d1 = gr;
      if (m_gp_prev) m_mode = !m_mode;
      chan_step(ts, t_lvl, t_run, t_hold, 1'b1, tp);
      chan_step(gs, g_lvl, g_run, g_hold, 1'b0, gp);
      m_gp_prev = gp;
      e = '{tp: tp, gp: gp, th: t_lvl, md: m_mode};
    end
  endtask

  // Inputs change on the falling edge; the expectation for the next rising edge is queued.
  task automatic drive(input bit rst, input bit tr, input bit gr, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      reset       = rst;
      trigger_raw = tr;
      toggle_raw  = gr;
      model_edge(rst, tr, gr, e);
      sb_q.push_back(e);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      cyc++;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks++;
        if ({trigger_pulse, toggle_pulse, trigger_held, mode} !== e) begin
          errors++;
          $display("FAIL outputs cycle %0d: got tp=%b gp=%b held=%b mode=%b, expected tp=%b gp=%b held=%b mode=%b",
                   cyc, trigger_pulse, toggle_pulse, trigger_held, mode, e.tp, e.gp, e.th, e.md);
        end
      end
    end
  end

  initial begin : stimulus
    int kind, n;
    drive(1, 0, 0, 3);
    // Clean press, bounce, two toggles, simultaneous press, reset mid-hold, long hold.
    drive(0, 1, 0, 30);  drive(0, 0, 0, 12);
    drive(0, 1, 0, 3);   drive(0, 0, 0, 1);  drive(0, 1, 0, 3);  drive(0, 0, 0, 12);
    drive(0, 0, 1, 10);  drive(0, 0, 0, 12); drive(0, 0, 1, 10); drive(0, 0, 0, 12);
    drive(0, 1, 1, 10);  drive(0, 0, 0, 12);
    drive(0, 1, 0, 10);  drive(1, 1, 0, 1);  drive(0, 1, 0, 20); drive(0, 0, 0, 12);
    drive(0, 1, 0, 60);  drive(0, 0, 0, 20);
    for (int seg = 0; seg < 300; seg++) begin
      kind = $urandom_range(0, 6);
      case (kind)
        0: drive(0, 0, 0, $urandom_range(1, 12));
        1: drive(0, 1, 0, $urandom_range(1, 45));
        2: drive(0, 0, 1, $urandom_range(1, 15));
        3: drive(0, 1, 1, 10);
        4: for (int i = 0; i < 10; i++) drive(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1);
        5: begin
          n = $urandom_range(2, 12);
          drive(0, 1, 1, n);
          drive(1, 1, 1'($urandom_range(0, 1)), 1);
          drive(0, 1, 0, $urandom_range(1, 14));
        end
        default: begin
          drive(0, 1, 1, $urandom_range(1, DB));
          drive(0, 0, 0, 1);
        end
      endcase
    end
    drive(0, 0, 0, 12);
    repeat (2) @(posedge clock);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
